// File: rtl/fetch_step_if.sv
// fetch_step_if: switch/button inputs, PC compare and fetch outputs of the fetch step controller.
interface fetch_step_if #(
  parameter int CNT_W = 16
);
  logic             RunSw;
  logic             StepBtn;
  logic             BreakEn;
  logic [31:0]      BreakPC;
  logic [31:0]      PCResult;
  logic             FetchEn;
  logic             Halted;
  logic [1:0]       State;
  logic [CNT_W-1:0] StepCount;
  modport master (
    output RunSw, StepBtn, BreakEn, BreakPC, PCResult,
    input  FetchEn, Halted, State, StepCount
  );
  modport slave (
    input  RunSw, StepBtn, BreakEn, BreakPC, PCResult,
    output FetchEn, Halted, State, StepCount
  );
endinterface

// File: rtl/fetch_step_controller.sv
// fetch_step_controller: RUN / single-STEP / HALT sequencer with PC breakpoint driving a 1-cycle fetch enable.
module fetch_step_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 100000000,
  parameter int CNT_W           = 16
) (
  input logic        Clk,
  input logic        Reset,
  fetch_step_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(RUN_DIV);
  localparam logic [1:0] HALT = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] BRK  = 2'd3;
  logic [1:0]       run_sync_q, run_sync_d;
  logic [1:0]       btn_sync_q, btn_sync_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic [VW-1:0]    div_q, div_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             run_s, btn_s, deb_done, step_req, brk_hit, div_last, fetch_en;
  always_comb begin
    run_s      = run_sync_q[1];
    btn_s      = btn_sync_q[1];
    run_sync_d = {run_sync_q[0], bus.RunSw};
    btn_sync_d = {btn_sync_q[0], bus.StepBtn};
    deb_done   = deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
    deb_cnt_d  = (btn_s == deb_q || deb_done) ? '0 : deb_cnt_q + 1'b1;
    deb_d      = (btn_s != deb_q && deb_done) ? btn_s : deb_q;
    deb_prev_d = deb_q;
    step_req   = deb_q && !deb_prev_q;
    brk_hit    = bus.BreakEn && bus.PCResult == bus.BreakPC;
    div_last   = div_q == VW'(RUN_DIV - 1);
    // the pulse is a pure function of registered state so it can never glitch or double up
    fetch_en   = state_q == STEP || (state_q == RUN && div_last);
    step_cnt_d = step_cnt_q + CNT_W'(fetch_en);
    state_d    = state_q;
    div_d      = '0;
    case (state_q)
      HALT: state_d = run_s ? RUN : step_req ? STEP : HALT;
      STEP: state_d = HALT;
      RUN: begin
        state_d = !run_s ? HALT : brk_hit ? BRK : RUN;
        div_d   = (run_s && !brk_hit && !div_last) ? div_q + 1'b1 : '0;
      end
      default: state_d = !run_s ? HALT : step_req ? STEP : BRK;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_sync_q <= '0;
      btn_sync_q <= '0;
      deb_cnt_q  <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      div_q      <= '0;
      state_q    <= HALT;
      step_cnt_q <= '0;
    end else begin
      run_sync_q <= run_sync_d;
      btn_sync_q <= btn_sync_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      div_q      <= div_d;
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
    end
  end
  assign bus.FetchEn   = fetch_en;
  assign bus.Halted    = state_q != RUN;
  assign bus.State     = state_q;
  assign bus.StepCount = step_cnt_q;
endmodule
